// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the block memory responder.
//   BLOCK_W / ADDR_W  - data block and request address widths
//   LATENCY_DEFAULT   - default request-to-mem_ready latency
//   mem_state_e       - responder FSM encoding
//   mem_dbg_t         - FSM/counter snapshot exposed for probing
package mem_pkg;

  localparam int BLOCK_W         = 128;
  localparam int ADDR_W          = 28;
  localparam int LATENCY_DEFAULT = 4;
  localparam int CNT_W           = 4;   // holds LATENCY-1 for LATENCY up to 15

  typedef logic [BLOCK_W-1:0] mem_block_t;
  typedef logic [ADDR_W-1:0]  mem_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RECOVER = 2'd3
  } mem_state_e;

  typedef struct packed {
    mem_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             op_write;
  } mem_dbg_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: block storage, 2^ADDR_BITS entries of BLOCK_W bits.
// One synchronous write port, one combinational read port, no reset
// (contents survive proc_reset_n and are undefined until written).
//   clk    - clock
//   we     - write enable, commits wdata to store[waddr] on the rising edge
//   waddr  - write index
//   wdata  - write block
//   raddr  - read index
//   rdata  - combinational read block
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  mem_block_t           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output mem_block_t           rdata
);

  mem_block_t store [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      store[waddr] <= wdata;
    end
  end

  assign rdata = store[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency block memory slave.
//
// Handshake: the initiator raises mem_read and/or mem_write with mem_addr
// (and mem_wdata for writes) and holds them until it samples mem_ready.
// The request is accepted on the first rising edge the responder is IDLE;
// address, data and op are latched there, so later changes to any request
// input do not affect the transaction in flight. mem_ready is a one-cycle
// pulse exactly LATENCY cycles after the accepting cycle; read data is
// valid in that cycle and held until the next read completes. A one-cycle
// RECOVER state follows every response, so accepts are LATENCY+2 apart.
//
// Ports:
//   clk           - clock, rising edge
//   proc_reset_n  - synchronous active-low reset
//   mem_read      - block read request
//   mem_write     - block write request (wins over read, flags mem_err)
//   mem_addr      - block address, low ADDR_BITS used (upper bits alias)
//   mem_wdata     - write block
//   mem_rdata     - registered read block
//   mem_ready     - registered completion pulse
//   mem_err       - sticky protocol error (read and write together)
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = LATENCY_DEFAULT
) (
  input  logic               clk,
  input  logic               proc_reset_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [BLOCK_W-1:0] mem_wdata,
  output logic [BLOCK_W-1:0] mem_rdata,
  output logic               mem_ready,
  output logic               mem_err
);

  mem_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  mem_block_t           wdata_q;
  logic                 op_write_q;
  logic                 ready_q, ready_d;
  mem_block_t           rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 op_write_eff;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 array_we;
  mem_block_t           array_rdata;

  mem_dbg_t             dbg;
  logic                 unused_addr_bits;
  logic                 unused_dbg;

  assign accept = (state_q == ST_IDLE) && (mem_read || mem_write);

  // With LATENCY=1 the response is loaded on the accepting edge itself,
  // before the latches hold the request, so IDLE looks at the live inputs.
  assign rd_addr      = (state_q == ST_IDLE) ? mem_addr[ADDR_BITS-1:0] : addr_q;
  assign op_write_eff = (state_q == ST_IDLE) ? mem_write : op_write_q;

  // Commit happens on the edge that ends RESP; a reset sampled on that
  // same edge aborts the write.
  assign array_we = (state_q == ST_RESP) && op_write_q && proc_reset_n;

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (array_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Counter value 1 here means it reaches 0 on this edge.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    ready_d = (state_d == ST_RESP);
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d = CNT_W'(LATENCY - 1);
      if (mem_read && mem_write) begin
        err_d = 1'b1;
      end
    end else if (state_q == ST_BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (state_d == ST_RESP && state_q != ST_RESP && !op_write_eff) begin
      rdata_d = array_rdata;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q     <= mem_addr[ADDR_BITS-1:0];
        wdata_q    <= mem_wdata;
        op_write_q <= mem_write;
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

  // Snapshot of the control state for hierarchical probes.
  assign dbg = '{state: state_q, cnt: cnt_q, op_write: op_write_q};

  // Address bits above ADDR_BITS alias by design; the reductions below
  // only mark those bits and the debug snapshot as intentionally unread.
  assign unused_addr_bits = ^mem_addr[ADDR_W-1:ADDR_BITS];
  assign unused_dbg       = ^dbg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Three instances
// (LATENCY 4, 1, 15) share clock and reset; index 0/1/2 selects one.
module tb_mem_responder;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]          rd_v, wr_v;
  logic [2:0][27:0]    addr_v;
  logic [2:0][127:0]   wdata_v;
  logic [2:0]          rdy_v, err_v;
  logic [2:0][127:0]   rdata_v;

  int n_vec = 0;
  int n_err = 0;
  int lat_v [3] = '{4, 1, 15};

  localparam logic [127:0] D0123  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DAA    = {16{8'hAA}};
  localparam logic [127:0] D55    = {16{8'h55}};
  localparam logic [127:0] D11    = {16{8'h11}};
  localparam logic [127:0] DFF    = {16{8'hFF}};
  localparam logic [127:0] D_SCR1 = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] D_SCR2 = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [127:0] B0     = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] MASK   = 128'h00000000FFFFFFFF0000000000000000;
  localparam logic [127:0] PATCH  = 128'h00000000DEADBEEF0000000000000000;
  localparam logic [127:0] MERGED = 128'h00112233DEADBEEF8899AABBCCDDEEFF;

  mem_responder #(.ADDR_BITS(8), .LATENCY(4)) u_l4 (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
    .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]), .mem_rdata(rdata_v[0]),
    .mem_ready(rdy_v[0]), .mem_err(err_v[0]));

  mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_l1 (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
    .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]), .mem_rdata(rdata_v[1]),
    .mem_ready(rdy_v[1]), .mem_err(err_v[1]));

  mem_responder #(.ADDR_BITS(8), .LATENCY(15)) u_l15 (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd_v[2]), .mem_write(wr_v[2]),
    .mem_addr(addr_v[2]), .mem_wdata(wdata_v[2]), .mem_rdata(rdata_v[2]),
    .mem_ready(rdy_v[2]), .mem_err(err_v[2]));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic r, input logic w,
                       input logic [27:0] a, input logic [127:0] wd);
    rd_v[d]    = r;
    wr_v[d]    = w;
    addr_v[d]  = a;
    wdata_v[d] = wd;
  endtask

  // Full transaction: request held until mem_ready, then dropped. Returns
  // mem_rdata seen in the ready cycle; leaves the instance back in IDLE.
  task automatic txn(input int d, input string tag, input logic r, input logic w,
                     input logic [27:0] a, input logic [127:0] wd,
                     input bit scramble, output logic [127:0] got);
    int k;
    drive(d, r, w, a, wd);
    @(posedge clk); #1;
    if (scramble) begin
      addr_v[d]  = a ^ 28'hFFFFFFF;
      wdata_v[d] = ~wd;
    end
    k = 1;
    while (rdy_v[d] !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 128'(k), 128'(lat_v[d]));
    got = rdata_v[d];
    drive(d, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {127'b0, rdy_v[d]}, 128'b0);
    if (r && !w) check({tag, "_hold"}, rdata_v[d], got);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] got, prev, merged;
    int j;
    bit seen;

    rd_v = '0; wr_v = '0; addr_v = '0; wdata_v = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {125'b0, rdy_v}, 128'b0);
    check("rst_err",   {125'b0, err_v}, 128'b0);
    check("rst_rdata", rdata_v[0], 128'b0);
    check("rst_state", 128'(u_l4.dbg.state), 128'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read, LATENCY=4
    txn(0, "w5", 1'b0, 1'b1, 28'h0000005, D0123, 1'b0, got);
    check("w5_err", {127'b0, err_v[0]}, 128'b0);
    txn(0, "r5", 1'b1, 1'b0, 28'h0000005, '0, 1'b0, got);
    check("r5_data", got, D0123);

    // Upper address bits alias
    txn(0, "w103", 1'b0, 1'b1, 28'h0000103, DAA, 1'b0, got);
    txn(0, "r003", 1'b1, 1'b0, 28'h0000003, '0, 1'b0, got);
    check("alias_data", got, DAA);

    // Inputs scrambled after accept must not leak in (scrambled addr = 0xDF)
    txn(0, "wdf", 1'b0, 1'b1, 28'h00000DF, D_SCR2, 1'b0, got);
    txn(0, "w20s", 1'b0, 1'b1, 28'h0000020, D_SCR1, 1'b1, got);
    txn(0, "r20", 1'b1, 1'b0, 28'h0000020, '0, 1'b0, got);
    check("scr_data20", got, D_SCR1);
    txn(0, "rdf", 1'b1, 1'b0, 28'h00000DF, '0, 1'b0, got);
    check("scr_datadf", got, D_SCR2);

    // Request held across completion: accepts are LATENCY+2 apart
    drive(0, 1'b1, 1'b0, 28'h0000020, '0);
    @(posedge clk); #1;
    j = 1;
    while (rdy_v[0] !== 1'b1 && j < 40) begin
      @(posedge clk); #1;
      j++;
    end
    check("held_first_latency", 128'(j), 128'd4);
    @(posedge clk); #1;
    check("held_pulse", {127'b0, rdy_v[0]}, 128'b0);
    j = 1;
    while (rdy_v[0] !== 1'b1 && j < 40) begin
      @(posedge clk); #1;
      j++;
    end
    check("held_gap", 128'(j), 128'd6);
    check("held_data", rdata_v[0], D_SCR1);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Read and write together: write wins, mem_err sticky, rdata untouched
    prev = rdata_v[0];
    txn(0, "both", 1'b1, 1'b1, 28'h0000007, D55, 1'b0, got);
    check("both_err", {127'b0, err_v[0]}, 128'd1);
    check("both_rdata_kept", got, prev);
    txn(0, "r7", 1'b1, 1'b0, 28'h0000007, '0, 1'b0, got);
    check("r7_data", got, D55);
    check("r7_err_sticky", {127'b0, err_v[0]}, 128'd1);

    // Reset in BUSY cycle 2 aborts an uncommitted write
    txn(0, "w9a", 1'b0, 1'b1, 28'h0000009, D11, 1'b0, got);
    drive(0, 1'b0, 1'b1, 28'h0000009, DFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy", 128'(u_l4.dbg.state), 128'(ST_BUSY));
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("abort_ready", {127'b0, rdy_v[0]}, 128'b0);
    check("abort_rdata", rdata_v[0], 128'b0);
    check("abort_err",   {127'b0, err_v[0]}, 128'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy_v[0] === 1'b1) seen = 1'b1;
    end
    check("abort_no_ready", {127'b0, seen}, 128'b0);
    txn(0, "r9", 1'b1, 1'b0, 28'h0000009, '0, 1'b0, got);
    check("abort_data", got, D11);

    // Read-modify-write initiator at LATENCY 1 and 15
    for (int d = 1; d < 3; d++) begin
      txn(d, $sformatf("rmw%0d_w", d), 1'b0, 1'b1, 28'h0000012, B0, 1'b0, got);
      txn(d, $sformatf("rmw%0d_r", d), 1'b1, 1'b0, 28'h0000012, '0, 1'b0, got);
      check($sformatf("rmw%0d_orig", d), got, B0);
      merged = (got & ~MASK) | (PATCH & MASK);
      txn(d, $sformatf("rmw%0d_wm", d), 1'b0, 1'b1, 28'h0000012, merged, 1'b0, got);
      txn(d, $sformatf("rmw%0d_rb", d), 1'b1, 1'b0, 28'h0000012, '0, 1'b0, got);
      check($sformatf("rmw%0d_merged", d), got, MERGED);
      check($sformatf("rmw%0d_err", d), {127'b0, err_v[d]}, 128'b0);
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
